// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative HI/LO multiply/divide unit.
// One bit per cycle over WIDTH cycles on operand magnitudes, then a single
// sign-correction cycle. MULTU/MULT are always present; DIVU/DIV are only
// built when MULT_DIV_UNIT_DIV_EN is defined. Without that macro, a divide
// request completes immediately with done and leaves hi/lo untouched.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// RUN   | WIDTH iterations of shift-add multiply / restoring divide
// SIGN  | sign correction, hi/lo loaded on the exit edge
// DONE  | done pulse; start here issues the next op with no bubble
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] W_ONE    = WIDTH'(1);
    localparam logic [PW-1:0]    P_ONE    = PW'(1);

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t           state, state_nx;
    logic             go_run;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, mq, opd;
    logic             neg_a, neg_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] acc_step, mq_step;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] hi_nx, lo_nx;
`ifdef MULT_DIV_UNIT_DIV_EN
    logic             is_div;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH:0]   div_shift, div_diff;
`endif

    function automatic logic [WIDTH-1:0] twos(input logic [WIDTH-1:0] v);
        return ~v + W_ONE;
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? twos(v) : v;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state, status outputs and operand-capture strobe.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        go_run   = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
`ifdef MULT_DIV_UNIT_DIV_EN
                    state_nx = RUN;
                    go_run   = 1'b1;
`else
                    if (op[1]) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = RUN;
                        go_run   = 1'b1;
                    end
`endif
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CW'(1)) state_nx = SIGN;
            end
            SIGN: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One iteration step: shift-add multiply, or restoring divide when enabled.
    always_comb begin
        mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opd} : '0);
        acc_step = mul_sum[WIDTH:1];
        mq_step  = {mul_sum[0], mq[WIDTH-1:1]};
`ifdef MULT_DIV_UNIT_DIV_EN
        div_shift = {acc, mq[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd};
        if (is_div) begin
            acc_step = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            mq_step  = {mq[WIDTH-2:0], ~div_diff[WIDTH]};
        end
`endif
    end

    // Sign-corrected result; divide by zero bypasses correction entirely.
    always_comb begin
        prod           = {acc, mq};
        {hi_nx, lo_nx} = (neg_a ^ neg_b) ? (~prod + P_ONE) : prod;
`ifdef MULT_DIV_UNIT_DIV_EN
        if (is_div) begin
            if (opd == '0) begin
                hi_nx = a_q;
                lo_nx = '1;
            end else begin
                lo_nx = (neg_a ^ neg_b) ? twos(mq) : mq;
                hi_nx = neg_a ? twos(acc) : acc;
            end
        end
`endif
    end

    // Datapath: capture magnitudes on issue, iterate in RUN, load hi/lo out of SIGN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            acc   <= '0;
            mq    <= '0;
            opd   <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            hi    <= '0;
            lo    <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div <= 1'b0;
            a_q    <= '0;
`endif
        end else if (go_run) begin
            cnt   <= CNT_INIT;
            acc   <= '0;
            neg_a <= op[0] & src_a[WIDTH-1];
            neg_b <= op[0] & src_b[WIDTH-1];
`ifdef MULT_DIV_UNIT_DIV_EN
            is_div <= op[1];
            a_q    <= src_a;
            mq     <= op[1] ? mag(src_a, op[0]) : mag(src_b, op[0]);
            opd    <= op[1] ? mag(src_b, op[0]) : mag(src_a, op[0]);
`else
            mq  <= mag(src_b, op[0]);
            opd <= mag(src_a, op[0]);
`endif
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            acc <= acc_step;
            mq  <= mq_step;
        end else if (state == SIGN) begin
            hi <= hi_nx;
            lo <= lo_nx;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, model-checked random ops and
// hand-written latency / back-to-back / ignored-start / reset sequences.
module tb_mult_div_unit;

    logic        clk, rst, start, busy, done;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, hi, lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_hi, last_lo;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0]        p;
        logic signed [63:0] sa64, sb64;
        logic signed [31:0] sa, sb;
        sa   = a;
        sb   = b;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        p    = '0;
        eh   = '0;
        el   = '0;
        case (o)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = sa64 * sb64; eh = p[63:32]; el = p[31:0]; end
            2'b10: begin
                if (b == 0) begin eh = a; el = '1; end
                else begin el = a / b; eh = a % b; end
            end
            default: begin
                if (b == 0) begin eh = a; el = '1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin eh = '0; el = a; end
                else begin el = 32'(sa / sb); eh = 32'(sa % sb); end
            end
        endcase
    endfunction

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%0h lo=%0h expected no done", hi, lo);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.nm, "_hi"}, {32'b0, hi}, {32'b0, mon_e.hi});
                check({mon_e.nm, "_lo"}, {32'b0, lo}, {32'b0, mon_e.lo});
            end
        end
    end

    // Issue at the current time (caller sits between edges), then follow to done.
    // lat counts edges after the sampling edge; pulses of start at j==p0/p1 carry junk operands.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string nm,
                          input int p0, input int p1, output int lat, output int nbusy);
        sbq.push_back('{eh, el, nm});
        last_hi = eh;
        last_lo = el;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        lat   = -1;
        nbusy = 0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            start = (j == p0) || (j == p1);
            op    = 2'($urandom);
            src_a = $urandom;
            src_b = $urandom;
            if (busy) nbusy++;
            if (done) begin
                lat = j;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 80 cycles", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, nb, ndone;
        logic [1:0]  ro;
        logic [31:0] ra, rb, eh, el;

        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
        vecs.push_back('{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back('{2'b00, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800});
        vecs.push_back('{2'b01, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
`ifdef MULT_DIV_UNIT_DIV_EN
        vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{2'b10, 32'd100,       32'd7,         32'd2,         32'd14});
        vecs.push_back('{2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
        vecs.push_back('{2'b11, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{2'b10, 32'd5,         32'd9,         32'd5,         32'd0});
`endif

        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;
        last_hi = '0;
        last_lo = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        rst = 1'b1;

        // Full-scale MULTU: latency and busy window.
        @(negedge clk);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", -1, -1, lat, nb);
        check("multu_max_latency", 64'(lat), 64'd33);
        check("multu_max_busy_cycles", 64'(nb), 64'd33);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                   $sformatf("vec%0d", i), -1, -1, lat, nb);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
        end

        for (int i = 0; i < 12; i++) begin
`ifdef MULT_DIV_UNIT_DIV_EN
            ro = 2'($urandom_range(0, 3));
`else
            ro = 2'($urandom_range(0, 1));
`endif
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
            model(ro, ra, rb, eh, el);
            @(negedge clk);
            run_op(ro, ra, rb, eh, el, $sformatf("rnd%0d", i), -1, -1, lat, nb);
        end

        // Back-to-back: second MULT issued in the done cycle of the first.
        @(negedge clk);
        run_op(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "b2b_first", -1, -1, lat, nb);
        run_op(2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "b2b_second", -1, -1, lat, nb);
        check("b2b_gap_cycles", 64'(lat + 1), 64'd34);

        // start pulsed mid-RUN and in SIGN with other operands is ignored.
        @(negedge clk);
        run_op(2'b00, 32'h1234_5678, 32'h0000_0100, 32'h0000_0012, 32'h3456_7800, "ignore", 5, 32, lat, nb);
        check("ignore_latency", 64'(lat), 64'd33);
        check("ignore_busy_cycles", 64'(nb), 64'd33);

        // Reset ten cycles into a MULTU: immediate clear, no done afterwards.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        src_a = 32'hFFFF_FFFF;
        src_b = 32'hFFFF_FFFF;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_hi", {32'b0, hi}, 64'd0);
        check("midrst_lo", {32'b0, lo}, 64'd0);
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        rst   = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);

        // start on the very first edge after reset release.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, "post_rst", -1, -1, lat, nb);
        check("post_rst_latency", 64'(lat), 64'd33);

`ifndef MULT_DIV_UNIT_DIV_EN
        // No divider: divide ops complete in one edge and leave hi/lo alone.
        @(negedge clk);
        run_op(2'b10, 32'h1234_5678, 32'h0000_0000, last_hi, last_lo, "nodiv_divu", -1, -1, lat, nb);
        check("nodiv_divu_latency", 64'(lat), 64'd0);
        check("nodiv_divu_busy", 64'(nb), 64'd0);
        @(negedge clk);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, last_hi, last_lo, "nodiv_div", -1, -1, lat, nb);
        check("nodiv_div_latency", 64'(lat), 64'd0);
        check("nodiv_div_busy", 64'(nb), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
